// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_t;

  // State names carry a prefix so they do not collide with the DIV opcode.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the datapath (master) and the MDU (slave).
interface mdu_hilo_if import mdu_pkg::*; #(
  parameter int unsigned WIDTH = MDU_ITERS
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring step for divide.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic             out_bit
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_hi} + (in_bit ? {1'b0, operand} : '0);
    rem_sh = {acc_hi, in_bit};
    diff   = WIDTH'(rem_sh - {1'b0, operand});
    if (div_mode) begin
      out_bit     = (rem_sh >= {1'b0, operand});
      acc_hi_next = out_bit ? diff : rem_sh[WIDTH-1:0];
    end else begin
      // sum[0] is the finished product bit that drops into the low word
      out_bit     = sum[0];
      acc_hi_next = sum[WIDTH:1];
    end
  end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/DIV unit owning HI/LO; fixed WIDTH+1 cycle busy window.
// Signed MULT/DIV only when MDU_SIGNED_EN is defined, otherwise they act as MULTU/DIVU.
module mdu_hilo import mdu_pkg::*; #(
  parameter int unsigned WIDTH = MDU_ITERS
) (
  input  logic      clk,
  input  logic      reset,
  mdu_hilo_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic             dz;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] step_hi;
  logic             step_bit;
  logic             div_mode_c;
  logic             in_bit_c;
`ifdef MDU_SIGNED_EN
  logic             sgn_op;
  logic             neg_q;
  logic             neg_r;
  logic             is_div;
`endif

  assign div_mode_c = (state == ST_DIV);
  assign in_bit_c   = div_mode_c ? acc[WIDTH-1] : acc[0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode    (div_mode_c),
    .acc_hi      (acc[ACC_W-1:WIDTH]),
    .in_bit      (in_bit_c),
    .operand     (opnd),
    .acc_hi_next (step_hi),
    .out_bit     (step_bit)
  );

  // Operand magnitudes at accept time
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
`ifdef MDU_SIGNED_EN
    sgn_op = (bus.op == MULT) || (bus.op == DIV);
    if (sgn_op && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (sgn_op && bus.b[WIDTH-1]) b_mag = -bus.b;
`endif
  end

  // Final HI/LO with sign correction and divide-by-zero override
  always_comb begin
    fix_hi = acc[ACC_W-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
    if (is_div) begin
      if (neg_q) fix_lo = -acc[WIDTH-1:0];
      if (neg_r) fix_hi = -acc[ACC_W-1:WIDTH];
    end else if (neg_q) begin
      {fix_hi, fix_lo} = -acc;
    end
`endif
    if (dz) fix_lo = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dz       <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
`ifdef MDU_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MULT, MULTU: begin
                state    <= ST_MUL;
                bus.busy <= 1'b1;
                cnt      <= '0;
                acc      <= {WIDTH'(0), b_mag};
                opnd     <= a_mag;
                dz       <= 1'b0;
`ifdef MDU_SIGNED_EN
                neg_q    <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= 1'b0;
                is_div   <= 1'b0;
`endif
              end
              DIV, DIVU: begin
                state    <= ST_DIV;
                bus.busy <= 1'b1;
                cnt      <= '0;
                acc      <= {WIDTH'(0), a_mag};
                opnd     <= b_mag;
                dz       <= (bus.b == '0);
`ifdef MDU_SIGNED_EN
                neg_q    <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= sgn_op && bus.a[WIDTH-1];
                is_div   <= 1'b1;
`endif
              end
              MTHI:    bus.hi <= bus.a;
              MTLO:    bus.lo <= bus.a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          acc <= {step_hi, step_bit, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_DIV: begin
          acc <= {step_hi, acc[WIDTH-2:0], step_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          bus.hi   <= fix_hi;
          bus.lo   <= fix_lo;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic reference model checked every cycle plus literal pins.
module tb_mdu_hilo;
  import mdu_pkg::*;

`ifdef MDU_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  mdu_hilo_if #(.WIDTH(32)) bus ();
  mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: result computed arithmetically at accept, published after 33 more edges
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  int          m_left;

  task automatic calc(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    hi = 32'd0;
    lo = 32'd0;
    if (op == MULT && SGN) begin
      p = 64'(longint'(sa) * longint'(sb));
      {hi, lo} = p;
    end else if (op == MULT || op == MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      {hi, lo} = p;
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (op == DIV && SGN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else begin
        lo = 32'(sa / sb);
        hi = 32'(sa % sb);
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (bus.start) begin
        case (bus.op)
          MULT, MULTU, DIV, DIVU: begin
            calc(bus.op, bus.a, bus.b, r_hi, r_lo);
            m_left = 33;
            m_busy = 1'b1;
          end
          MTHI: m_hi = bus.a;
          MTLO: m_lo = bus.a;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = NONE;
  endtask

  // Returns at the negedge where done is seen; busy_cnt counts busy cycles up to then
  task automatic wait_done(output int busy_cnt);
    int k;
    busy_cnt = 0;
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: got timeout expected done within 100 cycles");
    end
  endtask

  task automatic run(input string name, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bc;
    issue(op, a, b);
    wait_done(bc);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
    chk({name, "_busy_cycles"}, 32'(bc), 32'd33);
  endtask

  initial begin
    int bc;
    bus.start = 1'b0; bus.op = NONE; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);

    run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("done_width", 32'(bus.done), 32'd0);

    run("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD, SGN ? 32'hFFFF_FFFF : 32'h0000_0006, 32'hFFFF_FFEB);
    run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, SGN ? 32'hFFFF_FFFF : 32'h0000_0001,
        SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
    run("divu_by0", DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, SGN ? 32'h0 : 32'h8000_0000,
        SGN ? 32'h8000_0000 : 32'h0);
    run("div_neg_by0", DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);

    // MTHI while busy is dropped; after done it lands
    issue(MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    issue(MTHI, 32'h1234, 32'd0);
    wait_done(bc);
    chk("mthi_busy_hi", bus.hi, 32'd0);
    chk("mthi_busy_lo", bus.lo, 32'd15);
    @(negedge clk);
    issue(MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_lo", bus.lo, 32'd15);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    issue(MTLO, 32'hCAFE_0001, 32'd0);
    chk("mtlo_lo", bus.lo, 32'hCAFE_0001);

    // NONE and an undefined opcode do nothing
    issue(NONE, 32'h5555_5555, 32'd1);
    issue(mdu_op_t'(3'd7), 32'h5555_5555, 32'd1);
    chk("noop_busy", 32'(bus.busy), 32'd0);
    chk("noop_hi", bus.hi, 32'h1234);
    chk("noop_lo", bus.lo, 32'hCAFE_0001);

    // Reset sampled at E10 of a DIVU aborts it
    issue(DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);

    run("multu_2x3", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    // Back-to-back start in the done cycle
    run("div_100_m7", DIV, 32'd100, 32'hFFFF_FFF9, SGN ? 32'd2 : 32'd100, SGN ? 32'hFFFF_FFF2 : 32'd0);
    run("divu_plain", DIVU, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_BEEF, 32'h0000_DEAD);
    run("mult_negneg", MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, SGN ? 32'h0 : 32'hFFFF_FFFB,
        SGN ? 32'h6 : 32'h0000_0006);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
